// File: rtl/decoder8_scan_ctrl.sv
// decoder8_scan_ctrl: drives a 3-to-8 active-low decoder (e3/e2n/e1n, 3-bit select) so that
// eight multiplexed display digits are lit one at a time. Each slot is BLANK cycles dark and
// then PRESCALE cycles of dwell. Frames of eight DATA_W digits arrive over valid/ready. They are
// double-buffered and become visible only at the end of the slot-7 dwell.
// Latency: a frame accepted in IDLE shows at slot 0 after BLANK cycles. Later frames show from
// the next frame boundary. All outputs are registered.
// Backpressure: o_frame_ready is low while the pending buffer holds an uncommitted frame.
// It rises in the cycle after that frame is committed.
// Optional feature: define DECODER8_SCAN_BRIGHT_EN to add i_bright[3:0]. Within dwell, the
// digit is lit only while dwell_cnt < ((bright+1)*PRESCALE)>>4.
// Ports:
//   clk, rst_n       clock (rising edge) and async active-low reset.
//   i_frame_valid    upstream frame available.
//   o_frame_ready    pending buffer empty.
//   i_frame_data     digit i lives in bits [i*DATA_W +: DATA_W].
//   i_digit_mask     per-slot enable, sampled when a slot's blank phase starts.
//   o_sel            decoder select.
//   o_e3/o_e2n/o_e1n decoder enables.
//   o_digit_data     active-frame value of the current slot.
//   o_frame_done     single-cycle pulse on the last dwell cycle of slot 7.
module decoder8_scan_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 4,
  parameter int DATA_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_frame_valid,
  output logic                  o_frame_ready,
  input  logic [8*DATA_W-1:0]   i_frame_data,
  input  logic [7:0]            i_digit_mask,
`ifdef DECODER8_SCAN_BRIGHT_EN
  input  logic [3:0]            i_bright,
`endif
  output logic [2:0]            o_sel,
  output logic                  o_e3,
  output logic                  o_e2n,
  output logic                  o_e1n,
  output logic [DATA_W-1:0]     o_digit_data,
  output logic                  o_frame_done
);

  localparam int CNT_MAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

  state_t                r_state, w_next_state;
  logic [CNT_W-1:0]      r_cnt, w_next_cnt;
  logic [2:0]            r_slot, w_next_slot;
  logic [8*DATA_W-1:0]   r_active, w_next_active;
  logic [8*DATA_W-1:0]   r_pend, w_next_pend;
  logic                  r_pend_vld, w_next_pend_vld;
  logic                  r_mask_bit;
  logic                  r_frame_ready;
  logic                  r_frame_done;
  logic                  r_e3, r_e2n, r_e1n;
  logic [2:0]            r_sel;
  logic [DATA_W-1:0]     r_digit;
  logic                  w_xfer, w_boundary, w_blank_entry, w_lit, w_en_next;

  assign w_xfer     = i_frame_valid && r_frame_ready;
  assign w_boundary = (r_state == S_DWELL) && (r_slot == 3'd7) && (r_cnt == PRE_LAST);

`ifdef DECODER8_SCAN_BRIGHT_EN
  logic [3:0]  r_bright;
  logic [31:0] w_on_cycles;
  // Lit window is evaluated on the counter value the next cycle will show, so that the
  // registered enables line up with the dwell cycle they belong to.
  assign w_on_cycles = ((32'(r_bright) + 32'd1) * 32'(PRESCALE)) >> 4;
  assign w_lit       = 32'(w_next_cnt) < w_on_cycles;
`else
  assign w_lit = 1'b1;
`endif

  // Next-state, slot/counter sequencing and buffer movement.
  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    w_next_slot     = r_slot;
    w_next_active   = r_active;
    w_next_pend     = r_pend;
    w_next_pend_vld = r_pend_vld;
    w_blank_entry   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_next_state  = S_BLANK;
          w_next_cnt    = '0;
          w_next_slot   = 3'd0;
          w_blank_entry = 1'b1;
        end
      end
      S_BLANK: begin
        if (r_cnt == BLK_LAST) begin
          w_next_state = S_DWELL;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (r_cnt == PRE_LAST) begin
          w_next_state  = S_BLANK;
          w_next_cnt    = '0;
          w_next_slot   = r_slot + 3'd1;
          w_blank_entry = 1'b1;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // The first frame skips the pending stage. At a boundary with nothing pending,
    // a frame arriving in that same cycle also goes straight to active.
    if (r_state == S_IDLE) begin
      if (w_xfer) w_next_active = i_frame_data;
    end else if (w_boundary) begin
      if (r_pend_vld) begin
        w_next_active   = r_pend;
        w_next_pend_vld = 1'b0;
      end else if (w_xfer) begin
        w_next_active = i_frame_data;
      end
    end else if (w_xfer) begin
      w_next_pend     = i_frame_data;
      w_next_pend_vld = 1'b1;
    end
  end

  // The mask bit was latched on blank entry, which precedes every dwell cycle.
  assign w_en_next = (w_next_state == S_DWELL) && r_mask_bit && w_lit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_slot        <= 3'd0;
      r_active      <= '0;
      r_pend        <= '0;
      r_pend_vld    <= 1'b0;
      r_mask_bit    <= 1'b0;
      r_frame_ready <= 1'b1;
      r_frame_done  <= 1'b0;
      r_e3          <= 1'b0;
      r_e2n         <= 1'b1;
      r_e1n         <= 1'b1;
      r_sel         <= 3'd0;
      r_digit       <= '0;
`ifdef DECODER8_SCAN_BRIGHT_EN
      r_bright      <= 4'd15;
`endif
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_slot        <= w_next_slot;
      r_active      <= w_next_active;
      r_pend        <= w_next_pend;
      r_pend_vld    <= w_next_pend_vld;
      r_frame_ready <= !w_next_pend_vld;
      r_frame_done  <= (w_next_state == S_DWELL) && (w_next_slot == 3'd7) &&
                       (w_next_cnt == PRE_LAST);
      r_e3          <= w_en_next;
      r_e2n         <= !w_en_next;
      r_e1n         <= !w_en_next;
      if (w_blank_entry) begin
        r_sel      <= w_next_slot;
        r_digit    <= w_next_active[int'(w_next_slot) * DATA_W +: DATA_W];
        r_mask_bit <= i_digit_mask[w_next_slot];
`ifdef DECODER8_SCAN_BRIGHT_EN
        r_bright   <= i_bright;
`endif
      end
    end
  end

  assign o_frame_ready = r_frame_ready;
  assign o_frame_done  = r_frame_done;
  assign o_e3          = r_e3;
  assign o_e2n         = r_e2n;
  assign o_e1n         = r_e1n;
  assign o_sel         = r_sel;
  assign o_digit_data  = r_digit;

endmodule

// File: tb/tb_decoder8_scan_ctrl.sv
module tb_decoder8_scan_ctrl;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 2;
  localparam int DATA_W   = 4;
  localparam int SLOT     = BLANK + PRESCALE;
  localparam int FRAME    = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [31:0] frame_data = 32'h0;
  logic [7:0]  digit_mask = 8'hFF;
  logic        frame_ready, e3, e2n, e1n, frame_done;
  logic [2:0]  sel;
  logic [3:0]  digit_data;
`ifdef DECODER8_SCAN_BRIGHT_EN
  logic [3:0]  bright = 4'd15;
`endif

  decoder8_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK(BLANK), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_frame_valid(frame_valid), .o_frame_ready(frame_ready),
    .i_frame_data(frame_data), .i_digit_mask(digit_mask),
`ifdef DECODER8_SCAN_BRIGHT_EN
    .i_bright(bright),
`endif
    .o_sel(sel), .o_e3(e3), .o_e2n(e2n), .o_e1n(e1n),
    .o_digit_data(digit_data), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan is a single cycle index m_k within the frame;
  // slot and phase follow by division, the frame buffers are plain words.
  bit          m_run;
  int          m_k;
  logic [31:0] m_active, m_pend;
  bit          m_pend_vld;
  bit          m_mask;
  logic [3:0]  m_digit;
  int          m_bright;
  bit          m_xfer;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_active = 0; m_pend = 0; m_pend_vld = 0;
      m_mask = 0; m_digit = 0; m_bright = 15;
    end else begin
      m_xfer = frame_valid && !m_pend_vld;
      if (!m_run) begin
        if (m_xfer) begin
          m_active = frame_data;
          m_run = 1;
          m_k = 0;
          m_mask = digit_mask[0];
          m_digit = m_active[3:0];
`ifdef DECODER8_SCAN_BRIGHT_EN
          m_bright = int'(bright);
`endif
        end
      end else begin
        if (m_k == FRAME - 1) begin
          if (m_pend_vld) begin
            m_active = m_pend;
            m_pend_vld = 0;
          end else if (m_xfer) begin
            m_active = frame_data;
          end
        end else if (m_xfer) begin
          m_pend = frame_data;
          m_pend_vld = 1;
        end
        m_k = (m_k + 1) % FRAME;
        if (m_k % SLOT == 0) begin
          m_mask = digit_mask[m_k / SLOT];
          m_digit = m_active[(m_k / SLOT) * 4 +: 4];
`ifdef DECODER8_SCAN_BRIGHT_EN
          m_bright = int'(bright);
`endif
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  int c_slot, c_ph;
  bit c_en, c_done;
  always @(negedge clk) begin
    c_slot = 0; c_en = 0; c_done = 0;
    if (m_run) begin
      c_slot = m_k / SLOT;
      c_ph   = m_k % SLOT;
      c_en   = (c_ph >= BLANK) && m_mask &&
               ((c_ph - BLANK) < (((m_bright + 1) * PRESCALE) >> 4));
      c_done = (m_k == FRAME - 1);
    end
    check("sel", 32'(sel), 32'(c_slot));
    check("e3", 32'(e3), 32'(c_en));
    check("e2n", 32'(e2n), 32'(!c_en));
    check("e1n", 32'(e1n), 32'(!c_en));
    check("digit_data", 32'(digit_data), 32'(m_digit));
    check("frame_ready", 32'(frame_ready), 32'(!m_pend_vld));
    check("frame_done", 32'(frame_done), 32'(c_done));
  end

  int done_cnt, done_at, on_cnt, guard;

  initial begin
    // Held reset.
    repeat (20) @(negedge clk);
    check("rst_e3", 32'(e3), 0);
    check("rst_e2n", 32'(e2n), 1);
    check("rst_sel", 32'(sel), 0);
    check("rst_ready", 32'(frame_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // First frame, full mask: slot timing and frame_done position.
    frame_data = 32'h76543210; frame_valid = 1'b1;
    @(posedge clk); #1 frame_valid = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (frame_done) begin done_cnt++; done_at = k; end
      if (k == 1) check("k1_blank_off", 32'(e3), 0);
      if (k == 2) begin
        check("k2_sel", 32'(sel), 0);
        check("k2_on", 32'(e3), 1);
        check("k2_digit", 32'(digit_data), 0);
      end
      if (k == 6) begin
        check("k6_sel", 32'(sel), 1);
        check("k6_off", 32'(e3), 0);
      end
      if (k == 27) check("k27_digit", 32'(digit_data), 4);
    end
    check("done_count", 32'(done_cnt), 1);
    check("done_cycle", 32'(done_at + 1), 48);

    // Alternate mask: even slots dark for their whole period.
    digit_mask = 8'hAA;
    on_cnt = 0; done_at = -1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (e3) on_cnt++;
      if (frame_done) done_at = k;
      if (k == 2) check("mask_slot0_off", 32'(e3), 0);
      if (k == 8) check("mask_slot1_on", 32'(e3), 1);
    end
    check("mask_on_cycles", 32'(on_cnt), 16);
    check("mask_period", 32'(done_at + 1), 48);

    // New frame during slot 3: held back until the boundary.
    repeat (21) @(negedge clk);
    frame_data = 32'hFFFFFFFF; frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    check("pend_ready_low", 32'(frame_ready), 0);
    repeat (24) @(negedge clk);
    check("old_slot7_digit", 32'(digit_data), 7);
    repeat (3) @(negedge clk);
    check("new_slot0_digit", 32'(digit_data), 32'hF);
    check("ready_after_commit", 32'(frame_ready), 1);

    // Transfer landing exactly on the boundary with nothing pending.
    repeat (47) @(negedge clk);
    frame_data = 32'h1234567A; frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    check("bnd_slot0_digit", 32'(digit_data), 32'hA);
    check("bnd_ready", 32'(frame_ready), 1);
    repeat (8) @(negedge clk);
    check("bnd_slot1_digit", 32'(digit_data), 7);

    // Random traffic, mask and brightness.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      frame_valid = ($urandom_range(0, 15) == 0);
      frame_data  = $urandom;
      if ($urandom_range(0, 7) == 0) digit_mask = 8'($urandom);
`ifdef DECODER8_SCAN_BRIGHT_EN
      if ($urandom_range(0, 7) == 0) bright = 4'($urandom);
`endif
    end
    frame_valid = 1'b0;

    // Reset during dwell of slot 5.
    guard = 0;
    while (m_k != 5 * SLOT + BLANK + 1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reach_slot5_dwell", 32'(m_k), 32'(5 * SLOT + BLANK + 1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_e3", 32'(e3), 0);
    check("midrst_e2n", 32'(e2n), 1);
    check("midrst_e1n", 32'(e1n), 1);
    check("midrst_sel", 32'(sel), 0);
    check("midrst_digit", 32'(digit_data), 0);
    check("midrst_ready", 32'(frame_ready), 1);
    check("midrst_done", 32'(frame_done), 0);
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_sel", 32'(sel), 0);
    check("idle_e3", 32'(e3), 0);

    // Restart and a little more random traffic.
    frame_data = 32'h0F1E2D3C; frame_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      frame_valid = ($urandom_range(0, 15) == 0);
      frame_data  = $urandom;
      if ($urandom_range(0, 7) == 0) digit_mask = 8'($urandom);
    end
    frame_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder8_scan_ctrl.md
Name: decoder8_scan_ctrl

Overview:
- Upstream sequencer for the 3-to-8 active-low decoder (e3/e2n/e1n enables, 3-bit select). Drives one output of an 8-digit multiplexed display at a time.
- Scans 8 digit slots continuously, with blanking between slots to prevent ghosting.
- Frames of eight 4-bit digit values arrive through a valid/ready handshake. They are double-buffered and committed only at frame boundaries.

Parameters:
- PRESCALE, 1000: dwell cycles per digit slot (>=1).
- BLANK, 4: blanking cycles before each dwell (>=1).
- DATA_W, 4: bits per digit value; frame_data width is 8*DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_valid  in  1  upstream frame available.
- frame_ready  out  1  pending buffer empty, can accept.
- frame_data  in  8*DATA_W  digit i in bits [i*DATA_W +: DATA_W].
- digit_mask  in  8  per-slot enable, sampled at each BLANK entry.
- sel  out  3  decoder select (in[2:0]).
- e3  out  1  decoder active-high enable.
- e2n  out  1  decoder active-low enable.
- e1n  out  1  decoder active-low enable.
- digit_data  out  DATA_W  active-frame value for current slot.
- frame_done  out  1  one-cycle pulse at end of slot 7 dwell.

Behaviour:
- Reset (async assert, sync release): state IDLE, sel=0, e3=0, e2n=1, e1n=1, digit_data=0, frame_ready=1, frame_done=0; active and pending buffers invalid. Reset mid-scan aborts immediately; outputs take the reset values.
- All outputs are registered.
- Enable outputs: "on" means e3=1, e2n=0, e1n=0. "Off" means e3=0, e2n=1, e1n=1.
- Handshake: transfer when frame_valid && frame_ready at a rising edge. Data is written to the pending buffer and frame_ready drops the next cycle. frame_ready rises the cycle after pending is committed.
- States:
  - IDLE: enables off. On the first transfer, data goes directly to the active buffer, then BLANK with slot 0.
  - BLANK: enables off for BLANK cycles. On entry, sel and digit_data update to the current slot and the slot's mask bit is latched. Then go to DWELL.
  - DWELL: PRESCALE cycles. Enables are on if the latched mask bit=1, otherwise off; the slot still consumes its full time. At the last dwell cycle, slot+1 (mod 8) goes to BLANK.
- Period: every slot is BLANK+PRESCALE cycles; a full frame is 8*(BLANK+PRESCALE).
- Frame boundary = last DWELL cycle of slot 7:
  - frame_done=1 for that single cycle.
  - If pending is valid, it moves to active and pending is cleared.
  - Slot wraps to 0.
- Transfer and boundary in the same cycle (pending empty): the new frame goes directly to active and pending stays empty.
- No new frame: the active frame repeats indefinitely.
- frame_data and digit_mask changes mid-slot have no effect until the next commit or BLANK entry respectively.

Optional Feature:
- Macro: DECODER8_SCAN_BRIGHT_EN.
- Enabled:
  - Extra input bright[3:0].
  - Within DWELL, enables are on only while dwell_cnt < ((bright+1)*PRESCALE)>>4; otherwise off.
  - bright is sampled at BLANK entry.
  - bright=15 gives full dwell on. If the computed on-time is 0, the slot stays dark.
- Disabled: no bright port; full dwell on for masked-in slots.

Test Plan (PRESCALE=4, BLANK=2, DATA_W=4):
- Reset, then hold rst_n=0 20 cycles -> e3=0, e2n=1, e1n=1, sel=0, frame_ready=1, frame_done=0 throughout.
- Send frame 0x76543210 with mask 0xFF -> after 2 blank cycles, sel=0/digit_data=0 with enables on for 4 cycles. Enables are off on each slot transition. Slots 1..7 follow every 6 cycles. frame_done pulses once at cycle 48 of the scan.
- Mask 0b1010_1010 -> slots 0,2,4,6 keep enables off for their full 6 cycles. Slots 1,3,5,7 are on for 4 cycles. Frame period is still 48.
- During slot 3, send 0xFFFFFFFF -> frame_ready=0 the next cycle. digit_data keeps the old values through slot 7, shows F from slot 0 of the next frame, and frame_ready=1 after commit.
- Assert rst_n=0 during DWELL of slot 5 -> outputs are at reset values in the same cycle. After release, state is IDLE until a new frame arrives.
- With DECODER8_SCAN_BRIGHT_EN, PRESCALE=16, bright=3 -> enables are on for 4 of 16 dwell cycles per masked-in slot.
